sram_vga_scan: RTL and testbench
================================

# sram_vga_scan

Downstream consumer of the SRAM framebuffer: once the framebuffer fill stage has finished writing, this block owns the SRAM in read-only mode and continuously scans it out as a 640x480 VGA raster. It generates VGA counters and syncs, drives SRAM read addresses ahead of the raster, and converts each word's upper byte (the Julia iteration value) into 8-bit R/G/B. It sits between the shared SRAM pins and the board VGA DAC.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line (≤1024)
- H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal porch/sync lengths in clocks
- V_ACTIVE, 480, visible lines (≤512)
- V_FP, 10; V_SYNC, 2; V_BP, 33: vertical porch/sync lengths in lines
- BASE_ADDR, 20'h00000, SRAM word address of pixel (0,0)

Ports:
- clk  in  1  pixel clock (25 MHz)
- rst  in  1  asynchronous, active-high reset
- scan_en  in  1  level; frame fill complete, scanning permitted
- sram_addr  out  20  SRAM word address
- sram_dq  in  16  SRAM read data
- ce_n, ub_n, lb_n  out  1 each  constant 0
- oe_n  out  1  SRAM output enable, active low
- we_n  out  1  constant 1 (never writes)
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- hsync_n, vsync_n  out  1 each  active-low syncs
- blank_n  out  1  low outside active video
- frame_done  out  1  one-cycle pulse at last clock of each frame

## Operation
- Counters: hcnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), vcnt 0..V_TOTAL-1 (525). hcnt wraps to 0 and increments vcnt; vcnt wraps to 0 after V_TOTAL-1.
- States: IDLE, SCAN. Reset -> IDLE.
- IDLE: hcnt=vcnt=0, oe_n=1, outputs at reset values. scan_en=1 -> SCAN next cycle, first counted position (0,0).
- SCAN: counters run every clock. scan_en deassert is ignored until the frame end (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1); if scan_en=0 at that cycle -> IDLE, else wrap and continue.
- Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE. hsync active for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on vcnt.
- Address: in active region sram_addr = BASE_ADDR + {vcnt[8:0], hcnt[9:0]}, modulo 2^20 (wrap, no error). Outside active: sram_addr=BASE_ADDR.
- oe_n=0 throughout SCAN, 1 in IDLE.
- Pixel value p = sram_dq[15:8]; sram_dq[7:0] ignored.
- Colour (without palette): vga_r=vga_g=vga_b=p. blank_n=0 forces R/G/B=0.
- frame_done: asserted at counter stage when hcnt=H_TOTAL-1, vcnt=V_TOTAL-1 in SCAN (undelayed).

## Timing
- Stage 0 (cycle t): counters at (h,v).
- Stage 1 (t+1): registered sram_addr for (h,v) presented; sram_dq sampled at end of t+1 (SRAM tAA ≤ 10 ns fits 40 ns).
- Stage 2 (t+2): registered vga_r/g/b, hsync_n, vsync_n, blank_n for (h,v). Syncs/blank delayed by the same 2 cycles; latency counter->VGA outputs exactly 2 clocks.
- IDLE->SCAN: first pixel (0,0) on outputs 3 clocks after the clk edge that samples scan_en=1.
- SCAN->IDLE: pipeline drains; last frame's final 2 stage outputs still emitted, then reset values.
- Reset values (asynchronous, any state, mid-frame included): sram_addr=0, oe_n=1, we_n=1, ce_n/ub_n/lb_n=0, R/G/B=0, hsync_n=1, vsync_n=1, blank_n=0, frame_done=0, state IDLE, counters 0, pipeline cleared.

## Configuration
- SRAM_VGA_PALETTE_EN defined: p mapped through a registered-stage palette in stage 2: vga_r = p, vga_g = {p[6:0],1'b0}, vga_b = ~p; p=8'hFF (max iteration, in-set) forces 0/0/0. Latency unchanged.
- Undefined: greyscale R=G=B=p, no palette logic.

## Test plan
- Reset mid-SCAN at (h=100,v=50): all outputs at reset values immediately (asynchronous), after release with scan_en=1 raster restarts at (0,0).
- scan_en rises, SRAM model holds word 16'h{h[7:0],8'h00} at address {v,h}: pixel (5,0) outputs R=G=B=8'h05 exactly 2 clocks after hcnt=5; sram_addr=20'h00005 at stage 1.
- Full frame: hsync_n low 96 clocks starting 2 clocks after hcnt=656; vsync_n low for lines 490-491; blank_n high exactly 640x480 clocks per frame; frame_done one pulse per 420000 clocks.
- scan_en dropped at (h=300,v=200): frame completes, frame_done pulses, then oe_n=1 and outputs idle; re-raise restarts at (0,0).
- BASE_ADDR=20'hFFF00: pixel (256,0) address wraps to 20'h00000.
- With SRAM_VGA_PALETTE_EN: p=8'h40 -> R=8'h40, G=8'h80, B=8'hBF; p=8'hFF -> 0/0/0.

Source files
------------

// File: rtl/sram_vga_scan.sv
// sram_vga_scan
//   Reads a finished SRAM framebuffer and scans it out as a VGA raster.
//   The block generates the raster counters and syncs. It drives SRAM read
//   addresses one clock ahead of the colour outputs. It turns the upper byte
//   of each SRAM word (the iteration value) into 8-bit R/G/B.
//
//   Pipeline: the counters are stage 0. The registered SRAM address is
//   stage 1. The registered colour, syncs and blank are stage 2.
//
//   Optional feature macro: SRAM_VGA_PALETTE_EN
//     defined   : stage 2 maps p through a palette (r=p, g=p<<1, b=~p), and p=8'hFF gives black
//     undefined : greyscale, r=g=b=p
//
// Ports
//   clk         pixel clock
//   rst         asynchronous active-high reset
//   scan_en     frame fill complete, scanning permitted (level)
//   sram_addr   SRAM word address (registered)
//   sram_dq     SRAM read data; only [15:8] is used
//   ce_n/ub_n/lb_n  tied low
//   oe_n        SRAM output enable, low while scanning
//   we_n        tied high, the block never writes
//   vga_r/g/b   pixel colour
//   hsync_n/vsync_n  active-low syncs
//   blank_n     low outside active video
//   frame_done  one-cycle pulse on the last counter position of a frame
//
// State | meaning
// IDLE  | counters parked at (0,0), SRAM output disabled, outputs at rest
// SCAN  | raster running; scan_en is only re-examined at frame end
module sram_vga_scan #(
  parameter int          H_ACTIVE  = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_ACTIVE  = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic [19:0] BASE_ADDR = 20'h00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  output logic [19:0] sram_addr,
  input  logic [15:0] sram_dq,
  output logic        ce_n,
  output logic        ub_n,
  output logic        lb_n,
  output logic        oe_n,
  output logic        we_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank_n,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // The counters must cover the address slices {vcnt[8:0], hcnt[9:0]}.
  localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VW = ($clog2(V_TOTAL) > 9) ? $clog2(V_TOTAL) : 9;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic          run;      // stage 0 holds a valid raster position
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  logic          h_last, v_last;
  logic          active0, hs0, vs0;
  logic [19:0]   pix_idx;

  assign h_last  = (hcnt == H_LAST);
  assign v_last  = (vcnt == V_LAST);
  assign active0 = run && (hcnt < H_ACT) && (vcnt < V_ACT);
  assign hs0     = run && (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs0     = run && (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign pix_idx = {1'b0, vcnt[8:0], hcnt[9:0]};

  assign frame_done = run && h_last && v_last;

  assign ce_n = 1'b0;
  assign ub_n = 1'b0;
  assign lb_n = 1'b0;
  assign we_n = 1'b1;

  // On the first SCAN cycle the counters are held at (0,0) and run is still
  // low. That makes (0,0) reach the VGA pins 3 clocks after scan_en is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      run   <= 1'b0;
      hcnt  <= '0;
      vcnt  <= '0;
      oe_n  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (scan_en) begin
            state <= SCAN;
            oe_n  <= 1'b0;
          end
        end
        SCAN: begin
          if (!run) begin
            run <= 1'b1;
          end else if (h_last) begin
            hcnt <= '0;
            if (v_last) begin
              vcnt <= '0;
              if (!scan_en) begin
                state <= IDLE;
                run   <= 1'b0;
                oe_n  <= 1'b1;
              end
            end else begin
              vcnt <= vcnt + 1'b1;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          run   <= 1'b0;
          oe_n  <= 1'b1;
        end
      endcase
    end
  end

  // Stage 1: address plus the timing flags that travel with it.
  logic s1_active, s1_hs, s1_vs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr <= 20'h00000;
      s1_active <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
    end else begin
      if (!run)
        sram_addr <= 20'h00000;
      else if (active0)
        sram_addr <= BASE_ADDR + pix_idx;   // wraps modulo 2^20
      else
        sram_addr <= BASE_ADDR;
      s1_active <= active0;
      s1_hs     <= hs0;
      s1_vs     <= vs0;
    end
  end

  // Stage 2: the SRAM word was addressed during stage 1 and is captured here.
  logic [7:0] p;
  logic       unused_low;

  assign p          = sram_dq[15:8];
  assign unused_low = ^sram_dq[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r   <= 8'h00;
      vga_g   <= 8'h00;
      vga_b   <= 8'h00;
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      blank_n <= 1'b0;
    end else begin
      hsync_n <= ~s1_hs;
      vsync_n <= ~s1_vs;
      blank_n <= s1_active;
      if (!s1_active) begin
        vga_r <= 8'h00;
        vga_g <= 8'h00;
        vga_b <= 8'h00;
      end else begin
`ifdef SRAM_VGA_PALETTE_EN
        // An iteration count of 8'hFF means the point is in the set, so it is drawn black.
        if (p == 8'hFF) begin
          vga_r <= 8'h00;
          vga_g <= 8'h00;
          vga_b <= 8'h00;
        end else begin
          vga_r <= p;
          vga_g <= {p[6:0], 1'b0};
          vga_b <= ~p;
        end
`else
        vga_r <= p;
        vga_g <= p;
        vga_b <= p;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sram_vga_scan.sv
module tb_sram_vga_scan;

  // dut0: reduced raster so that whole frames fit in a short run
  localparam int HA0 = 120, HF0 = 8, HS0 = 12, HB0 = 10;
  localparam int VA0 = 60,  VF0 = 3, VS0 = 2,  VB0 = 5;
  localparam int HT0 = HA0 + HF0 + HS0 + HB0;
  localparam int VT0 = VA0 + VF0 + VS0 + VB0;
  localparam int FRAME0 = HT0 * VT0;
  // dut1: lines longer than 256 pixels, base near the top of the address space
  localparam int HA1 = 260, HF1 = 4, HS1 = 6, HB1 = 5;
  localparam int VA1 = 4,   VF1 = 1, VS1 = 1, VB1 = 1;
  localparam logic [19:0] BASE1 = 20'hFFF00;

  localparam logic [48:0] RST_VEC = {20'h00000, 1'b1, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scan_en = 1'b0;
  logic scan_en1 = 1'b0;
  logic [7:0] key = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // dut0 signals
  logic [19:0] sram_addr0;
  logic [15:0] sram_dq0;
  logic ce_n0, ub_n0, lb_n0, oe_n0, we_n0;
  logic [7:0] r0, g0, b0;
  logic hs_n0, vs_n0, blank_n0, fd0;
  // dut1 signals
  logic [19:0] sram_addr1;
  logic [15:0] sram_dq1;
  logic ce_n1, ub_n1, lb_n1, oe_n1, we_n1;
  logic [7:0] r1, g1, b1;
  logic hs_n1, vs_n1, blank_n1, fd1;

  // SRAM contents as functions of the address
  function automatic logic [7:0] pix0(input logic [19:0] a);
    logic [7:0] t;
    t = a[17:10] * key;
    return a[7:0] ^ t;
  endfunction

  assign sram_dq0 = {pix0(sram_addr0), sram_addr0[15:8]};
  assign sram_dq1 = {sram_addr1[7:0], 8'h5A};

  sram_vga_scan #(
    .H_ACTIVE(HA0), .H_FP(HF0), .H_SYNC(HS0), .H_BP(HB0),
    .V_ACTIVE(VA0), .V_FP(VF0), .V_SYNC(VS0), .V_BP(VB0),
    .BASE_ADDR(20'h00000)
  ) dut0 (
    .clk(clk), .rst(rst), .scan_en(scan_en),
    .sram_addr(sram_addr0), .sram_dq(sram_dq0),
    .ce_n(ce_n0), .ub_n(ub_n0), .lb_n(lb_n0), .oe_n(oe_n0), .we_n(we_n0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0),
    .hsync_n(hs_n0), .vsync_n(vs_n0), .blank_n(blank_n0), .frame_done(fd0)
  );

  sram_vga_scan #(
    .H_ACTIVE(HA1), .H_FP(HF1), .H_SYNC(HS1), .H_BP(HB1),
    .V_ACTIVE(VA1), .V_FP(VF1), .V_SYNC(VS1), .V_BP(VB1),
    .BASE_ADDR(BASE1)
  ) dut1 (
    .clk(clk), .rst(rst), .scan_en(scan_en1),
    .sram_addr(sram_addr1), .sram_dq(sram_dq1),
    .ce_n(ce_n1), .ub_n(ub_n1), .lb_n(lb_n1), .oe_n(oe_n1), .we_n(we_n1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .hsync_n(hs_n1), .vsync_n(vs_n1), .blank_n(blank_n1), .frame_done(fd1)
  );

  function automatic logic [23:0] colour(input logic [7:0] p);
`ifdef SRAM_VGA_PALETTE_EN
    if (p == 8'hFF) return 24'h000000;
    return {p, p[6:0], 1'b0, ~p};
`else
    return {p, p, p};
`endif
  endfunction

  // ---------------- reference model for dut0 ----------------
  // The model keeps a flat cycle index m_n within the frame. A raster
  // position is (m_n % HT0, m_n / HT0). The two pipeline stages are records
  // of the positions that were current one and two clocks earlier.
  logic m_scan, m_run;
  int   m_n;
  logic s1_ok, s2_ok;
  int   s1_h, s1_y, s2_h, s2_y;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_scan <= 1'b0; m_run <= 1'b0; m_n <= 0;
      s1_ok <= 1'b0; s2_ok <= 1'b0;
      s1_h <= 0; s1_y <= 0; s2_h <= 0; s2_y <= 0;
    end else begin
      s1_ok <= m_run; s1_h <= m_n % HT0; s1_y <= m_n / HT0;
      s2_ok <= s1_ok; s2_h <= s1_h; s2_y <= s1_y;
      if (!m_scan) begin
        if (scan_en) m_scan <= 1'b1;
      end else if (!m_run) begin
        m_run <= 1'b1;
        m_n <= 0;
      end else if (m_n == FRAME0 - 1) begin
        m_n <= 0;
        if (!scan_en) begin
          m_scan <= 1'b0;
          m_run <= 1'b0;
        end
      end else begin
        m_n <= m_n + 1;
      end
    end
  end

  function automatic logic [19:0] addr0_of(input int h, input int y);
    if (h < HA0 && y < VA0) return 20'(y * 1024 + h);
    return 20'h00000;
  endfunction

  logic [48:0] exp_vec, obs_vec;
  always_comb begin
    logic act2;
    logic [19:0] ea;
    logic [23:0] ergb;
    logic ehs, evs;
    ea = s1_ok ? addr0_of(s1_h, s1_y) : 20'h00000;
    act2 = s2_ok && (s2_h < HA0) && (s2_y < VA0);
    ergb = act2 ? colour(pix0(addr0_of(s2_h, s2_y))) : 24'h000000;
    ehs = !(s2_ok && s2_h >= HA0 + HF0 && s2_h < HA0 + HF0 + HS0);
    evs = !(s2_ok && s2_y >= VA0 + VF0 && s2_y < VA0 + VF0 + VS0);
    exp_vec = {ea, !m_scan, ergb, ehs, evs, act2, m_run && (m_n == FRAME0 - 1)};
  end
  assign obs_vec = {sram_addr0, oe_n0, r0, g0, b0, hs_n0, vs_n0, blank_n0, fd0};

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_vec !== RST_VEC) begin
      errors++;
      $display("FAIL reset_vec0 got %h want %h", obs_vec, RST_VEC);
    end
    checks++;
    if ({ce_n0, ub_n0, lb_n0, we_n0, ce_n1, ub_n1, lb_n1, we_n1} !== 8'b0001_0001) begin
      errors++;
      $display("FAIL reset_consts got %b want 00010001",
               {ce_n0, ub_n0, lb_n0, we_n0, ce_n1, ub_n1, lb_n1, we_n1});
    end
    checks++;
    if ({sram_addr1, oe_n1, r1, g1, b1, hs_n1, vs_n1, blank_n1, fd1} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_vec1 got %h want %h",
               {sram_addr1, oe_n1, r1, g1, b1, hs_n1, vs_n1, blank_n1, fd1}, RST_VEC);
    end
    rst = 1'b0;
    repeat (1 + $urandom_range(0, 4)) @(negedge clk);
  endtask

  task automatic test_start_pixel;
    logic [23:0] c5;
    c5 = colour(pix0(20'h00005));
    scan_en = 1'b1;
    @(posedge clk);  // the edge that samples scan_en
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (blank_n0 !== (k >= 3)) begin
        errors++;
        $display("FAIL start_blank k=%0d got %b want %b", k, blank_n0, k >= 3);
      end
      if (k == 7) begin
        checks++;
        if (sram_addr0 !== 20'h00005) begin
          errors++;
          $display("FAIL addr_px5 got %h want 00005", sram_addr0);
        end
      end
      if (k == 8) begin
        checks++;
        if ({r0, g0, b0} !== c5) begin
          errors++;
          $display("FAIL rgb_px5 got %h want %h", {r0, g0, b0}, c5);
        end
      end
    end
  endtask

  task automatic test_full_frame;
    int blank_cnt = 0, fd_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    for (int i = 0; i < FRAME0; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL frame_vec i=%0d got %h want %h", i, obs_vec, exp_vec);
      end
      blank_cnt += int'(blank_n0);
      fd_cnt += int'(fd0);
      hs_cnt += int'(!hs_n0);
      vs_cnt += int'(!vs_n0);
    end
    checks++;
    if (blank_cnt != HA0 * VA0) begin
      errors++; $display("FAIL blank_count got %0d want %0d", blank_cnt, HA0 * VA0);
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++; $display("FAIL frame_done_count got %0d want 1", fd_cnt);
    end
    checks++;
    if (hs_cnt != HS0 * VT0) begin
      errors++; $display("FAIL hsync_count got %0d want %0d", hs_cnt, HS0 * VT0);
    end
    checks++;
    if (vs_cnt != VS0 * HT0) begin
      errors++; $display("FAIL vsync_count got %0d want %0d", vs_cnt, VS0 * HT0);
    end
  endtask

  task automatic test_reset_mid;
    int target = 50 * HT0 + 100;
    bit found = 0;
    for (int i = 0; i < 2 * FRAME0 && !found; i++) begin
      @(negedge clk);
      if (m_run && m_n == target) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL reset_mid_wait got timeout want position");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_vec !== RST_VEC) begin
      errors++; $display("FAIL reset_mid_async got %h want %h", obs_vec, RST_VEC);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    scan_en = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (blank_n0 !== (k == 3)) begin
        errors++;
        $display("FAIL restart_blank k=%0d got %b want %b", k, blank_n0, k == 3);
      end
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL restart_vec i=%0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_scan_drop;
    int target, fd_cnt = 0, idle_seen = 0;
    bit found = 0;
    target = $urandom_range(0, VT0 - 1) * HT0 + $urandom_range(0, HT0 - 1);
    for (int i = 0; i < 2 * FRAME0 && !found; i++) begin
      @(negedge clk);
      if (m_run && m_n == target) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL drop_wait got timeout want position");
    end
    scan_en = 1'b0;
    for (int i = 0; i < FRAME0 + 10 && idle_seen < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL drop_vec i=%0d got %h want %h", i, obs_vec, exp_vec);
      end
      fd_cnt += int'(fd0);
      if (oe_n0) idle_seen++;
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++; $display("FAIL drop_frame_done got %0d want 1", fd_cnt);
    end
    checks++;
    if (obs_vec !== RST_VEC) begin
      errors++; $display("FAIL drop_idle got %h want %h", obs_vec, RST_VEC);
    end
    repeat ($urandom_range(1, 6)) @(negedge clk);
    scan_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++; $display("FAIL reraise_vec i=%0d got %h want %h", i, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_base_wrap;
    logic [19:0] ea;
    logic [23:0] ec;
    scan_en1 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= HA1 + 4; k++) begin
      @(posedge clk); #1;
      // address of pixel h appears at k = h + 2, colour at k = h + 3
      if (k >= 2 && k - 2 < HA1) begin
        ea = BASE1 + 20'(k - 2);
        checks++;
        if (sram_addr1 !== ea) begin
          errors++; $display("FAIL wrap_addr h=%0d got %h want %h", k - 2, sram_addr1, ea);
        end
        if (k - 2 == 256) begin
          checks++;
          if (sram_addr1 !== 20'h00000) begin
            errors++; $display("FAIL wrap_addr256 got %h want 00000", sram_addr1);
          end
        end
      end
      if (k >= 3 && k - 3 < HA1) begin
        ec = colour(8'(k - 3));
        checks++;
        if ({r1, g1, b1} !== ec) begin
          errors++; $display("FAIL wrap_rgb h=%0d got %h want %h", k - 3, {r1, g1, b1}, ec);
        end
`ifdef SRAM_VGA_PALETTE_EN
        if (k - 3 == 8'h40 || k - 3 == 8'hFF) begin
          ec = (k - 3 == 8'h40) ? 24'h4080BF : 24'h000000;
          checks++;
          if ({r1, g1, b1} !== ec) begin
            errors++; $display("FAIL palette h=%0d got %h want %h", k - 3, {r1, g1, b1}, ec);
          end
        end
`endif
      end
    end
    scan_en1 = 1'b0;
  endtask

  initial begin
    key = 8'($urandom_range(1, 255));
    test_reset();
    test_start_pixel();
    test_full_frame();
    test_reset_mid();
    test_scan_drop();
    test_base_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
